core_mem_wb: RTL and testbench

- Memory-access and writeback stage of the core; the producing side of the EX forwarding interface.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the forwarding sources used by the execution stage: mem_regwrite/mem_regrd/mem_reg_data and wb_regwrite/wb_regrd/wb_reg_data.
- Runs word load/store requests to the data-memory port (ring node) with a req/ack handshake, and stalls the upstream pipeline while an access is outstanding.

---
 rtl/core_mem_wb.sv | 175 +++++++++++++++++
 tb/tb_core_mem_wb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_wb.sv
// Memory-access / writeback stage: EX/MEM and MEM/WB pipeline registers, a req/ack
// data-memory handshake with timeout, and the forwarding sources for the EX stage.
module core_mem_wb #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_data_to_mem,
  input  logic [4:0]  ex_dest_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_memtoreg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_regwrite,
  output logic [4:0]  mem_regrd,
  output logic [31:0] mem_reg_data,
  output logic        wb_regwrite,
  output logic [4:0]  wb_regrd,
  output logic [31:0] wb_reg_data,
  output logic        mem_addr_err,
  output logic        dmem_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        dropped_q, dropped_d;

  logic        exmem_valid_q, exmem_valid_d;
  logic [31:0] exmem_alu_q, exmem_alu_d;
  logic [31:0] exmem_wdata_q, exmem_wdata_d;
  logic [4:0]  exmem_rd_q, exmem_rd_d;
  logic        exmem_regwrite_q, exmem_regwrite_d;
  logic        exmem_memread_q, exmem_memread_d;
  logic        exmem_memwrite_q, exmem_memwrite_d;
  logic        exmem_memtoreg_q, exmem_memtoreg_d;

  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_regrd_q, wb_regrd_d;
  logic [31:0] wb_reg_data_q, wb_reg_data_d;

  logic        capture;
  logic        ex_memop_ok;
  logic        misaligned;
  logic        drop;
  logic [16:0] cnt_inc;

  assign mem_stall   = (state_q == S_WAIT) & ~dmem_ack;
  assign capture     = ~mem_stall;
  assign ex_memop_ok = ex_valid & (ex_memread | ex_memwrite) & (ex_alu_result[1:0] == 2'b00);
  assign misaligned  = exmem_valid_q & (exmem_memread_q | exmem_memwrite_q) &
                       (exmem_alu_q[1:0] != 2'b00);
  // An op is a bubble if it was misaligned or its access timed out.
  assign drop        = misaligned | dropped_q;
  assign cnt_inc     = {1'b0, wait_cnt_q} + 17'd1;

  always_comb begin
    exmem_valid_d    = exmem_valid_q;
    exmem_alu_d      = exmem_alu_q;
    exmem_wdata_d    = exmem_wdata_q;
    exmem_rd_d       = exmem_rd_q;
    exmem_regwrite_d = exmem_regwrite_q;
    exmem_memread_d  = exmem_memread_q;
    exmem_memwrite_d = exmem_memwrite_q;
    exmem_memtoreg_d = exmem_memtoreg_q;
    wb_regwrite_d    = wb_regwrite_q;
    wb_regrd_d       = wb_regrd_q;
    wb_reg_data_d    = wb_reg_data_q;
    dropped_d        = dropped_q;
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    timeout_d        = timeout_q;

    if (capture) begin
      exmem_valid_d    = ex_valid;
      exmem_alu_d      = ex_alu_result;
      exmem_wdata_d    = ex_data_to_mem;
      exmem_rd_d       = ex_dest_rd;
      exmem_regwrite_d = ex_regwrite;
      exmem_memread_d  = ex_memread;
      exmem_memwrite_d = ex_memwrite;
      exmem_memtoreg_d = ex_memtoreg;
      dropped_d        = 1'b0;
      wb_regwrite_d    = exmem_valid_q & exmem_regwrite_q & ~drop;
      wb_regrd_d       = exmem_rd_q;
      wb_reg_data_d    = exmem_memtoreg_q ? dmem_rdata : exmem_alu_q;
    end

    case (state_q)
      S_IDLE: begin
        wait_cnt_d = 16'd0;
        if (ex_memop_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_ack) begin
          wait_cnt_d = 16'd0;
          state_d    = ex_memop_ok ? S_WAIT : S_IDLE;
        end else if (cnt_inc == 17'(ACK_TIMEOUT)) begin
          // Abandon the access; the held instruction leaves as a bubble.
          wait_cnt_d = 16'd0;
          state_d    = S_IDLE;
          timeout_d  = 1'b1;
          dropped_d  = 1'b1;
        end else begin
          wait_cnt_d = cnt_inc[15:0];
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      wait_cnt_q       <= 16'd0;
      timeout_q        <= 1'b0;
      dropped_q        <= 1'b0;
      exmem_valid_q    <= 1'b0;
      exmem_alu_q      <= 32'd0;
      exmem_wdata_q    <= 32'd0;
      exmem_rd_q       <= 5'd0;
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      wb_regwrite_q    <= 1'b0;
      wb_regrd_q       <= 5'd0;
      wb_reg_data_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      timeout_q        <= timeout_d;
      dropped_q        <= dropped_d;
      exmem_valid_q    <= exmem_valid_d;
      exmem_alu_q      <= exmem_alu_d;
      exmem_wdata_q    <= exmem_wdata_d;
      exmem_rd_q       <= exmem_rd_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_memread_q  <= exmem_memread_d;
      exmem_memwrite_q <= exmem_memwrite_d;
      exmem_memtoreg_q <= exmem_memtoreg_d;
      wb_regwrite_q    <= wb_regwrite_d;
      wb_regrd_q       <= wb_regrd_d;
      wb_reg_data_q    <= wb_reg_data_d;
    end
  end

  assign dmem_req     = (state_q == S_WAIT);
  assign dmem_we      = dmem_req & exmem_memwrite_q;
  assign dmem_addr    = exmem_alu_q;
  assign dmem_wdata   = exmem_wdata_q;
  assign mem_regwrite = exmem_valid_q & exmem_regwrite_q & ~drop;
  assign mem_regrd    = exmem_rd_q;
  assign mem_reg_data = exmem_alu_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_regrd     = wb_regrd_q;
  assign wb_reg_data  = wb_reg_data_q;
  assign mem_addr_err = misaligned;
  assign dmem_timeout = timeout_q;

endmodule

// File: tb/tb_core_mem_wb.sv
// Scoreboard bench for core_mem_wb: directed vectors push expected memory and
// writeback transactions; a negedge monitor pops and compares them.
module tb_core_mem_wb;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_data_to_mem;
  logic [4:0]  ex_dest_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_regwrite;
  logic [4:0]  mem_regrd;
  logic [31:0] mem_reg_data;
  logic        wb_regwrite;
  logic [4:0]  wb_regrd;
  logic [31:0] wb_reg_data;
  logic        mem_addr_err;
  logic        dmem_timeout;

  int checks = 0;
  int failures = 0;
  logic prev_stall = 1'b0;

  // Expected memory transactions {we, addr, wdata} and register writes {rd, data}.
  logic [64:0] mem_q[$];
  logic [36:0] wb_q[$];

  core_mem_wb #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_data_to_mem(ex_data_to_mem),
    .ex_dest_rd(ex_dest_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_regwrite(mem_regwrite), .mem_regrd(mem_regrd),
    .mem_reg_data(mem_reg_data), .wb_regwrite(wb_regwrite), .wb_regrd(wb_regrd),
    .wb_reg_data(wb_reg_data), .mem_addr_err(mem_addr_err), .dmem_timeout(dmem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic m2r);
    ex_valid       = v;
    ex_alu_result  = alu;
    ex_data_to_mem = wd;
    ex_dest_rd     = rd;
    ex_regwrite    = rw;
    ex_memread     = mr;
    ex_memwrite    = mw;
    ex_memtoreg    = m2r;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic anyOutput();
    return |{mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_regwrite, mem_regrd,
             mem_reg_data, wb_regwrite, wb_regrd, wb_reg_data, mem_addr_err, dmem_timeout};
  endfunction

  // Monitor: completed handshakes and freshly loaded register writes.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req && dmem_ack) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL mem_unexpected: got we=%0b addr=0x%0h, expected no access",
                   dmem_we, dmem_addr);
        end else begin
          checkOutput("mem_txn", 64'({dmem_we, dmem_addr, dmem_wdata}), 64'(mem_q.pop_front()));
        end
      end
      if (!prev_stall && wb_regwrite) begin
        if (wb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no write",
                   wb_regrd, wb_reg_data);
        end else begin
          checkOutput("wb_txn", 64'({wb_regrd, wb_reg_data}), 64'(wb_q.pop_front()));
        end
      end
    end
    prev_stall = mem_stall;
  end

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    bubble();
    repeat (2) nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs", 64'(anyOutput()), 64'd0);

    // ALU op flows through EX/MEM then MEM/WB
    nextCycle();
    applyStimulus(1'b1, 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    wb_q.push_back({5'd5, 32'h1234});
    nextCycle();
    bubble();
    @(negedge clk);
    checkOutput("alu_mem_fwd", 64'({mem_regwrite, mem_regrd, mem_reg_data}), 64'({1'b1, 5'd5, 32'h1234}));
    checkOutput("alu_no_req", 64'({dmem_req, mem_stall}), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("alu_wb", 64'({wb_regwrite, wb_regrd, wb_reg_data}), 64'({1'b1, 5'd5, 32'h1234}));

    // Load with ack on the third request cycle
    nextCycle();
    applyStimulus(1'b1, 32'h40, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_q.push_back({1'b0, 32'h40, 32'd0});
    wb_q.push_back({5'd8, 32'hDEADBEEF});
    nextCycle();
    bubble();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("load_wait", 64'({dmem_req, dmem_we, dmem_addr, mem_stall}), 64'({1'b1, 1'b0, 32'h40, 1'b1}));
      nextCycle();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("load_ack", 64'({dmem_req, dmem_addr, mem_stall}), 64'({1'b1, 32'h40, 1'b0}));
    nextCycle();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    @(negedge clk);
    checkOutput("load_wb", 64'({dmem_req, wb_regrd, wb_reg_data}), 64'({1'b0, 5'd8, 32'hDEADBEEF}));

    // Back-to-back stores, each acked in its first request cycle
    nextCycle();
    applyStimulus(1'b1, 32'h10, 32'hAAAA0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_q.push_back({1'b1, 32'h10, 32'hAAAA0001});
    nextCycle();
    applyStimulus(1'b1, 32'h14, 32'hBBBB0002, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_q.push_back({1'b1, 32'h14, 32'hBBBB0002});
    dmem_ack = 1'b1;
    @(negedge clk);
    checkOutput("store1", 64'({dmem_req, dmem_we, dmem_addr, mem_stall}), 64'({1'b1, 1'b1, 32'h10, 1'b0}));
    nextCycle();
    bubble();
    @(negedge clk);
    checkOutput("store2", 64'({dmem_req, dmem_we, dmem_addr, mem_stall}), 64'({1'b1, 1'b1, 32'h14, 1'b0}));
    nextCycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("store_done", 64'({dmem_req, wb_regwrite}), 64'd0);

    // Misaligned load is dropped
    nextCycle();
    applyStimulus(1'b1, 32'h42, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    nextCycle();
    bubble();
    @(negedge clk);
    checkOutput("misalign_err", 64'({mem_addr_err, dmem_req, mem_stall, mem_regwrite}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    nextCycle();
    @(negedge clk);
    checkOutput("misalign_after", 64'({mem_addr_err, wb_regwrite}), 64'd0);

    // Timeout: four stalled request cycles, then sticky flag and a bubble
    nextCycle();
    applyStimulus(1'b1, 32'h80, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    nextCycle();
    bubble();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("timeout_wait", 64'({mem_stall, dmem_req, dmem_timeout}), 64'({1'b1, 1'b1, 1'b0}));
      nextCycle();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    checkOutput("timeout_hit", 64'({mem_stall, dmem_req, dmem_timeout, mem_regwrite}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
    nextCycle();
    @(negedge clk);
    checkOutput("timeout_bubble", 64'({wb_regwrite, dmem_req, dmem_timeout}), 64'({1'b0, 1'b0, 1'b1}));
    nextCycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("timeout_sticky", 64'(dmem_timeout), 64'd1);

    // Reset in the second request cycle
    nextCycle();
    applyStimulus(1'b1, 32'hC0, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
    nextCycle();
    bubble();
    @(negedge clk);
    checkOutput("rst_wait1", 64'(dmem_req), 64'd1);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555AAAA;
    @(negedge clk);
    checkOutput("rst_outputs", 64'(anyOutput()), 64'd0);
    nextCycle();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    @(negedge clk);
    checkOutput("rst_late_ack", 64'(anyOutput()), 64'd0);

    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("mem_q_drained", 64'(mem_q.size()), 64'd0);
    checkOutput("wb_q_drained", 64'(wb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
